// File: rtl/d_mem_responder_if.sv
// d_mem_responder_if
//   Request/response bundle between a CPU data-memory initiator and the
//   d_mem_responder memory model.
//   Request : req_valid, req_ready, req_we, req_adr (byte address), req_wdata
//   Response: rsp_valid (one-cycle strobe), rsp_rdata, rsp_err
//   Status  : busy (an access is in flight)
//   master  : the initiator (CPU side)
//   slave   : the responder (memory side)
interface d_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_adr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_adr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/d_mem_responder.sv
// d_mem_responder
//   Memory-side responder for the CPU data-memory port. Accepts one word
//   read or write per valid/ready handshake, waits WAIT_CYC wait states,
//   then returns a one-cycle response strobe with read data and an error
//   flag for misaligned or out-of-range addresses.
// Parameters
//   DEPTH     storage size in 32-bit words (power of 2, >= 2)
//   WAIT_CYC  wait states between accept and response (0..15)
// Ports
//   clk    system clock, all state changes on posedge
//   rst_n  asynchronous active-low reset (storage array is not reset)
//   bus    d_mem_responder_if.slave: request handshake, response strobe,
//          error flag and busy status
module d_mem_responder #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    d_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        lat_we;
    logic [31:0] lat_adr;
    logic [31:0] lat_wdata;

    logic        ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem [DEPTH];

    logic             accept;
    logic             enter_resp;
    logic             acc_we;
    logic [31:0]      acc_adr;
    logic [31:0]      acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;

    // With zero wait states the array access happens on the accept edge
    // itself, before the latch registers hold the request, so the access
    // fields come straight from the bus while in IDLE.
    always_comb begin
        accept     = (state == S_IDLE) && bus.req_valid;
        enter_resp = (accept && (WAIT_CYC == 0)) ||
                     ((state == S_WAIT) && (cnt == '0));

        if (state == S_IDLE) begin
            acc_we    = bus.req_we;
            acc_adr   = bus.req_adr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = lat_we;
            acc_adr   = lat_adr;
            acc_wdata = lat_wdata;
        end

        acc_idx = acc_adr[IDX_W+1:2];
        acc_err = (acc_adr[1:0] != 2'b00) || (acc_adr[31:IDX_W+2] != '0);
    end

    // The array sits in the reset block only so that no write can occur
    // while rst_n is low; it is never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_adr     <= '0;
            lat_wdata   <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we    <= bus.req_we;
                        lat_adr   <= bus.req_adr;
                        lat_wdata <= bus.req_wdata;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (WAIT_CYC == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= acc_err;
                if (!acc_err) begin
                    if (acc_we) begin
                        mem[acc_idx] <= acc_wdata;
                    end else begin
                        rsp_rdata_q <= mem[acc_idx];
                    end
                end
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// tb_d_mem_responder
//   Drives two responders (4 wait states and 0 wait states) with directed
//   accesses and checks every cycle against a cycle-age model of the
//   access, plus hand-computed latency, data and error expectations.
module tb_d_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AWB   = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    d_mem_responder_if bus0 ();
    d_mem_responder_if bus1 ();

    d_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    d_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic        in_valid [2];
    logic        in_we    [2];
    logic [31:0] in_adr   [2];
    logic [31:0] in_wd    [2];

    assign bus0.req_valid = in_valid[0];
    assign bus0.req_we    = in_we[0];
    assign bus0.req_adr   = in_adr[0];
    assign bus0.req_wdata = in_wd[0];
    assign bus1.req_valid = in_valid[1];
    assign bus1.req_we    = in_we[1];
    assign bus1.req_adr   = in_adr[1];
    assign bus1.req_wdata = in_wd[1];

    // {ready, busy, rsp_valid, rsp_err, rsp_rdata}
    logic [35:0] obs [2];
    assign obs[0] = {bus0.req_ready, bus0.busy, bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata};
    assign obs[1] = {bus1.req_ready, bus1.busy, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata};

    localparam logic [35:0] RST_VEC = {4'b1000, 32'h0};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An access is described by its age in cycles since the accept edge.
    // Latency L: array access and response on the edge where age reaches L,
    // back to idle one edge later.
    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic bit adr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    logic        m_active [2];
    int unsigned m_age    [2];
    logic        m_we     [2];
    logic [31:0] m_adr    [2];
    logic [31:0] m_wd     [2];
    logic        m_err    [2];
    logic [31:0] m_rdata  [2];
    logic [31:0] m_mem    [2][DEPTH];

    task model_access(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd);
        m_err[k] <= adr_bad(a);
        if (!we && !adr_bad(a)) m_rdata[k] <= m_mem[k][AWB'(a >> 2)];
        else                    m_rdata[k] <= 32'h0;
        if (we && !adr_bad(a))  m_mem[k][AWB'(a >> 2)] <= wd;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_active[i] <= 1'b0;
                m_age[i]    <= 0;
            end else if (m_active[i]) begin
                if (m_age[i] == lat_of(i)) begin
                    m_active[i] <= 1'b0;
                end else begin
                    m_age[i] <= m_age[i] + 1;
                    if (m_age[i] + 1 == lat_of(i))
                        model_access(i, m_we[i], m_adr[i], m_wd[i]);
                end
            end else if (in_valid[i]) begin
                m_active[i] <= 1'b1;
                m_age[i]    <= 0;
                m_we[i]     <= in_we[i];
                m_adr[i]    <= in_adr[i];
                m_wd[i]     <= in_wd[i];
                if (lat_of(i) == 0)
                    model_access(i, in_we[i], in_adr[i], in_wd[i]);
            end
        end
    end

    function automatic logic [35:0] exp_vec(input int i);
        logic v;
        v = m_active[i] && (m_age[i] == lat_of(i));
        return {~m_active[i], m_active[i], v, v & m_err[i], v ? m_rdata[i] : 32'h0};
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            check("cycle_dut0", obs[0], exp_vec(0));
            check("cycle_dut1", obs[1], exp_vec(1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_req(input int i, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, output bit ok);
        logic r;
        @(negedge clk); #1;
        in_valid[i] = 1'b1;
        in_we[i]    = we;
        in_adr[i]   = a;
        in_wd[i]    = wd;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            r = obs[i][35];
            @(posedge clk);
            if (r) ok = 1'b1;
            else begin
                @(negedge clk); #1;
            end
        end
        #1;
        in_valid[i] = 1'b0;
        if (!ok) check("accept_timeout", 36'd0, 36'd1);
    endtask

    task automatic access(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int unsigned lat);
        bit ok;
        bit got;
        rd  = 32'h0;
        er  = 1'b0;
        lat = 0;
        start_req(i, we, a, wd, ok);
        got = 1'b0;
        for (int n = 1; n <= 40 && !got && ok; n++) begin
            @(negedge clk);
            if (obs[i][33]) begin
                got = 1'b1;
                lat = n;
                rd  = obs[i][31:0];
                er  = obs[i][32];
            end
        end
        if (!got) check("rsp_timeout", 36'd0, 36'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int unsigned lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_we[i]    = 1'b0;
            in_adr[i]   = 32'h0;
            in_wd[i]    = 32'h0;
        end
        #12;
        check("reset_dut0", obs[0], RST_VEC);
        check("reset_dut1", obs[1], RST_VEC);
        @(negedge clk); #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // 1: write then read back, 4 wait states
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("t1_wr_lat", 36'(lat), 36'd5);
        check("t1_wr_err_rd", {3'b0, er, rd}, 36'h0);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("t1_rd_data", {3'b0, er, rd}, {4'b0, 32'hDEADBEEF});

        // 2: misaligned write is rejected and leaves the word intact
        access(0, 1'b1, 32'h12, 32'h12345678, rd, er, lat);
        check("t2_mis_err", {3'b0, er, rd}, {4'b0001, 32'h0});
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("t2_rd_data", {3'b0, er, rd}, {4'b0, 32'hDEADBEEF});

        // 3: out-of-range read and write; the write must not alias word 0
        access(0, 1'b0, 32'h400, 32'h0, rd, er, lat);
        check("t3_oor_rd", {3'b0, er, rd}, {4'b0001, 32'h0});
        access(0, 1'b1, 32'h0, 32'hA5A5A5A5, rd, er, lat);
        access(0, 1'b1, 32'h400, 32'hFFFFFFFF, rd, er, lat);
        check("t3_oor_wr", {3'b0, er, rd}, {4'b0001, 32'h0});
        access(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("t3_rd_word0", {3'b0, er, rd}, {4'b0, 32'hA5A5A5A5});

        // 4: req_valid held across two reads
        begin
            int t_acc [2];
            int nacc;
            int nready0;
            int nbusy;
            int npulse;
            t_acc[0] = 0; t_acc[1] = 0;
            nacc = 0; nready0 = 0; nbusy = 0; npulse = 0;
            @(negedge clk); #1;
            in_valid[0] = 1'b1;
            in_we[0]    = 1'b0;
            in_adr[0]   = 32'h10;
            for (int k = 0; k < 40 && nacc < 2; k++) begin
                @(negedge clk);
                if (nacc == 1) begin
                    if (!obs[0][35]) nready0++;
                    if (obs[0][34])  nbusy++;
                    if (obs[0][33])  npulse++;
                end
                if (obs[0][35]) begin
                    t_acc[nacc] = k;
                    nacc++;
                end
                @(posedge clk); #1;
                if (nacc == 1) in_adr[0] = 32'h0;
                if (nacc == 2) in_valid[0] = 1'b0;
            end
            in_valid[0] = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (obs[0][33]) npulse++;
            end
            check("t4_accept_gap", 36'(t_acc[1] - t_acc[0]), 36'd6);
            check("t4_ready_low", 36'(nready0), 36'd5);
            check("t4_busy_high", 36'(nbusy), 36'd5);
            check("t4_pulses", 36'(npulse), 36'd2);
        end

        // 5: reset during the second wait cycle abandons the write
        access(0, 1'b1, 32'h20, 32'h1, rd, er, lat);
        begin
            bit ok;
            start_req(0, 1'b1, 32'h20, 32'h2, ok);
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check("t5_rst_dut0", obs[0], RST_VEC);
            check("t5_rst_dut1", obs[1], RST_VEC);
            @(negedge clk); #1;
            rst_n = 1'b1;
        end
        access(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
        check("t5_rd_data", {3'b0, er, rd}, {4'b0, 32'h1});
        check("t5_rd_lat", 36'(lat), 36'd5);

        // 6: zero wait states
        access(1, 1'b1, 32'h10, 32'hCAFEF00D, rd, er, lat);
        check("t6_wr_lat", 36'(lat), 36'd1);
        access(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("t6_rd_lat", 36'(lat), 36'd1);
        check("t6_rd_data", {3'b0, er, rd}, {4'b0, 32'hCAFEF00D});
        check("t6_ready_in_resp", 36'(obs[1][35]), 36'd0);
        @(negedge clk);
        check("t6_ready_after", 36'(obs[1][35]), 36'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
